mem_copy_master: RTL and testbench

Initiator-side sequencer for the single-port data memory: accepts a block-copy command (source address, destination address, length), then drives the memory's Read_enable / Write_enable / Address / Write_data lines and consumes Data_out. It copies words one at a time and signals completion with a one-cycle done pulse. It sits between the datapath controller and the data memory. It is the memory's only master while busy.

---
 rtl/mem_copy_master_if.sv | 38 +++
 rtl/mem_copy_master.sv | 102 ++++++++++
 tb/tb_mem_copy_master.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_master_if.sv
// Command and memory-side signals of the block-copy sequencer.
// With MEM_COPY_CHECKSUM_EN defined, the interface also carries the running checksum.
interface mem_copy_master_if #(
    parameter int ADDR_BITS = 13,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 13
);
    logic                 start;
    logic [ADDR_BITS-1:0] src_addr;
    logic [ADDR_BITS-1:0] dst_addr;
    logic [LEN_BITS-1:0]  length;
    logic                 busy;
    logic                 done;
    logic                 Read_enable;
    logic                 Write_enable;
    logic [ADDR_BITS-1:0] Address;
    logic [DATA_BITS-1:0] Write_data;
    logic [DATA_BITS-1:0] Data_out;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_BITS-1:0] checksum;
`endif

    modport master (
        input  start, src_addr, dst_addr, length, Data_out,
        output busy, done, Read_enable, Write_enable, Address, Write_data
`ifdef MEM_COPY_CHECKSUM_EN
        , output checksum
`endif
    );

    modport slave (
        output start, src_addr, dst_addr, length, Data_out,
        input  busy, done, Read_enable, Write_enable, Address, Write_data
`ifdef MEM_COPY_CHECKSUM_EN
        , input checksum
`endif
    );
endinterface

// File: rtl/mem_copy_master.sv
// Block-copy sequencer: copies words one at a time (read, wait, write) and pulses done.
// Define MEM_COPY_CHECKSUM_EN to add a running sum of copied words.
module mem_copy_master #(
    parameter int ADDR_BITS = 13,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 13
) (
    input logic               CLK,
    input logic               RST,
    mem_copy_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD, WT, WR, DONE} state_e;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] src_q, dst_q;
    logic [LEN_BITS-1:0]  len_q, idx_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 busy_q;
    logic                 accept, last_word;
    logic [ADDR_BITS-1:0] idx_addr;

    assign accept    = (state_q == IDLE) && bus.start;
    assign last_word = (LEN_BITS'(idx_q + 1'b1) == len_q);
    assign idx_addr  = ADDR_BITS'(idx_q);

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start) state_d = (bus.length != '0) ? RD : DONE;
            RD:   state_d = WT;
            WT:   state_d = WR;
            WR:   state_d = last_word ? DONE : RD;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address is held through WT so the memory sees a stable read address.
    always_comb begin
        bus.Read_enable  = 1'b0;
        bus.Write_enable = 1'b0;
        bus.Address      = '0;
        bus.Write_data   = '0;
        bus.done         = 1'b0;
        unique case (state_q)
            RD: begin
                bus.Read_enable = 1'b1;
                bus.Address     = src_q + idx_addr;
            end
            WT: bus.Address = src_q + idx_addr;
            WR: begin
                bus.Write_enable = 1'b1;
                bus.Address      = dst_q + idx_addr;
                bus.Write_data   = data_q;
            end
            DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy = busy_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            if (accept) begin
                src_q  <= bus.src_addr;
                dst_q  <= bus.dst_addr;
                len_q  <= bus.length;
                idx_q  <= '0;
                busy_q <= (bus.length != '0);
            end else if (state_q == WR) begin
                idx_q <= idx_q + 1'b1;
                if (last_word) busy_q <= 1'b0;
            end
            if (state_q == WT) data_q <= bus.Data_out;
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_BITS-1:0] checksum_q;

    always_ff @(posedge CLK) begin
        if (RST)                 checksum_q <= '0;
        else if (accept)         checksum_q <= '0;
        else if (state_q == WR)  checksum_q <= checksum_q + data_q;
    end

    assign bus.checksum = checksum_q;
`endif
endmodule

// File: tb/tb_mem_copy_master.sv
// Scoreboarded bench for mem_copy_master: behavioural memory, expected reads/writes queued at command issue.
// Checksum checks are compiled in when MEM_COPY_CHECKSUM_EN is defined.
module tb_mem_copy_master;
    typedef struct {
        logic [12:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_copy_master_if #(.ADDR_BITS(13), .DATA_BITS(32), .LEN_BITS(13)) bus ();

    mem_copy_master #(.ADDR_BITS(13), .DATA_BITS(32), .LEN_BITS(13)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    bit [31:0]   mem [0:8191];
    logic        pl_en;
    logic [12:0] pl_addr;
    logic [31:0] pl_data;

    logic [12:0] rdq [$];
    wr_t         wrq [$];
    int          n_vec = 0, n_err = 0;
    int          re_cnt = 0, we_cnt = 0, done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (pl_en)                  mem[pl_addr] <= pl_data;
        else if (bus.Write_enable)  mem[bus.Address] <= bus.Write_data;
        if (bus.Read_enable)        bus.Data_out <= mem[bus.Address];
    end

    always @(negedge clk) begin
        wr_t e;
        if (bus.Read_enable) begin
            re_cnt++;
            if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
            else                 chk("rd_addr", bus.Address, rdq.pop_front());
        end
        if (bus.Write_enable) begin
            we_cnt++;
            if (wrq.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                e = wrq.pop_front();
                chk("wr_addr", bus.Address, e.addr);
                chk("wr_data", bus.Write_data, e.data);
            end
        end
        if (bus.Read_enable && bus.Write_enable) chk("re_we_excl", 1, 0);
        if (bus.done) done_cnt++;
    end

    task automatic poke(input logic [12:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // inj_start / inj_rst: cycle after acceptance at which to inject a stray start or a reset (0 = none).
    task automatic run_copy(input logic [12:0] s, input logic [12:0] d, input logic [12:0] n,
                            input int inj_start, input int inj_rst);
        logic [31:0] ov [int];
        logic [31:0] v, sum;
        logic [12:0] sa, da;
        int dc, bc, d0, lim;
        bit got, aborted;
        sum = 0;
        for (int i = 0; i < int'(n); i++) begin
            sa = s + 13'(i);
            da = d + 13'(i);
            v  = ov.exists(int'(sa)) ? ov[int'(sa)] : mem[sa];
            rdq.push_back(sa);
            wrq.push_back('{da, v});
            ov[int'(da)] = v;
            sum += v;
        end
        d0 = done_cnt; dc = 0; bc = 0; got = 0; aborted = 0;
        lim = 3 * int'(n) + 8;
        @(negedge clk);
        bus.start = 1'b1; bus.src_addr = s; bus.dst_addr = d; bus.length = n;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.src_addr = 13'($urandom); bus.dst_addr = 13'($urandom); bus.length = 13'($urandom);
        for (int cyc = 1; cyc <= lim; cyc++) begin
            @(negedge clk);
            if (cyc == 1) chk("busy_rise", bus.busy, n != 0);
`ifdef MEM_COPY_CHECKSUM_EN
            if (cyc == 1) chk("cksum_clear", bus.checksum, 0);
`endif
            if (inj_start != 0 && cyc == inj_start) begin
                bus.start = 1'b1; bus.src_addr = 13'd50; bus.dst_addr = 13'd600; bus.length = 13'd2;
            end
            if (inj_start != 0 && cyc == inj_start + 1) bus.start = 1'b0;
            if (inj_rst != 0 && cyc == inj_rst) rst = 1'b1;
            if (inj_rst != 0 && cyc == inj_rst + 1) begin
                chk("rst_outs", {bus.busy, bus.done, bus.Read_enable, bus.Write_enable,
                                 bus.Address, bus.Write_data}, 0);
                rst = 1'b0;
                rdq.delete();
                wrq.delete();
                aborted = 1;
                break;
            end
            if (bus.busy) bc++;
            if (bus.done) begin
                got = 1;
                dc  = cyc;
                break;
            end
        end
        if (!aborted) begin
            if (!got) chk("done_timeout", 0, 1);
            else begin
                chk("done_cycle", dc, (n == 0) ? 1 : 3 * int'(n) + 1);
                chk("busy_cycles", bc, 3 * int'(n));
`ifdef MEM_COPY_CHECKSUM_EN
                chk("cksum_done", bus.checksum, sum);
`endif
            end
        end
        repeat (4) @(negedge clk);
        chk("done_pulses", done_cnt - d0, aborted ? 0 : 1);
        chk("rdq_left", rdq.size(), 0);
        chk("wrq_left", wrq.size(), 0);
    endtask

    initial begin
        int r0, w0;
        rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.length = '0;
        for (int i = 0; i < 100; i++) poke(13'(i), 32'(i));
        poke(13'd8190, 32'd7);
        poke(13'd8191, 32'd8);
        poke(13'd302, 32'hAAAA);
        @(negedge clk);
        chk("reset_outs", {bus.busy, bus.done, bus.Read_enable, bus.Write_enable,
                           bus.Address, bus.Write_data}, 0);
`ifdef MEM_COPY_CHECKSUM_EN
        chk("reset_cksum", bus.checksum, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // basic copy
        run_copy(13'd0, 13'd200, 13'd4, 0, 0);
        for (int i = 0; i < 4; i++) chk("basic_mem", mem[200 + i], i);

        // zero length: no memory traffic at all
        r0 = re_cnt; w0 = we_cnt;
        run_copy(13'd5, 13'd10, 13'd0, 0, 0);
        chk("zero_no_rd", re_cnt - r0, 0);
        chk("zero_no_wr", we_cnt - w0, 0);
        chk("zero_mem", mem[10], 10);

        // wrap-around with forward propagation
        poke(13'd0, 32'd9);
        run_copy(13'd8190, 13'd8191, 13'd3, 0, 0);
        chk("wrap_8191", mem[8191], 7);
        chk("wrap_0", mem[0], 7);
        chk("wrap_1", mem[1], 7);

        // start while busy is ignored
        run_copy(13'd20, 13'd500, 13'd4, 4, 0);
        for (int i = 0; i < 4; i++) chk("busy_start_mem", mem[500 + i], 20 + i);
        chk("busy_start_nodst", mem[600], 0);

        // reset in WR of the second word
        w0 = we_cnt;
        run_copy(13'd30, 13'd300, 13'd4, 0, 6);
        chk("rst_writes", we_cnt - w0, 2);
        chk("rst_mem0", mem[300], 30);
        chk("rst_mem1", mem[301], 31);
        chk("rst_mem2", mem[302], 32'hAAAA);

        run_copy(13'd40, 13'd700, 13'd2, 0, 0);
        chk("post_rst_mem0", mem[700], 40);
        chk("post_rst_mem1", mem[701], 41);

        // checksum source block 10..14 (sum 60), then a fresh command clears it
        run_copy(13'd10, 13'd400, 13'd5, 0, 0);
`ifdef MEM_COPY_CHECKSUM_EN
        chk("cksum_60", bus.checksum, 60);
`endif
        run_copy(13'd2, 13'd800, 13'd1, 0, 0);
        chk("last_mem", mem[800], 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
